// File: rtl/bram_bus_port_if.sv
// Core bus bundle: 16-bit address/data plus rw and valid, in both directions.
// The slave side samples the *_i signals and drives the *_o signals.
interface bram_bus_port_if;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    modport slave (
        input  addr_i, data_i, rw_i, valid_i,
        output addr_o, data_o, rw_o, valid_o
    );

    modport master (
        output addr_i, data_i, rw_i, valid_i,
        input  addr_o, data_o, rw_o, valid_o
    );
endinterface

// File: rtl/bram_bus_port.sv
// Core-bus responder exposing one port of a dual-port RAM as 16-bit registers.
// Each bus beat takes a fixed 4-cycle pipeline; in-range reads get RAM data substituted.
module bram_bus_port #(
    parameter int BASE_ADDR = 0,
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bram_bus_port_if.slave               bus,
    output logic [$clog2(RAM_DEPTH)-1:0] bram_addr,
    output logic [RAM_WIDTH-1:0]         bram_din,
    output logic                         bram_we,
    output logic                         bram_en,
    input  logic [RAM_WIDTH-1:0]         bram_dout
);
    localparam int N_CHUNKS   = (RAM_WIDTH + 15) / 16;
    localparam int CHUNK_BITS = $clog2(N_CHUNKS);
    localparam int CB1        = (CHUNK_BITS == 0) ? 1 : CHUNK_BITS;
    localparam int AW         = $clog2(RAM_DEPTH);
    localparam int SPAN       = RAM_DEPTH << CHUNK_BITS;
    localparam int PAD_W      = 16 << CB1;
    localparam int LAST_IDX   = N_CHUNKS - 1;
    localparam logic [CB1-1:0] CHUNK_MASK = CB1'((1 << CHUNK_BITS) - 1);
    localparam logic [CB1-1:0] LAST_CHUNK = CB1'(LAST_IDX);
    localparam logic [15:0]    BASE       = 16'(BASE_ADDR);

    // Padding to a power-of-two chunk count makes hole chunks read back as zero.
    function automatic logic [15:0] chunk_of(input logic [PAD_W-1:0] v, input logic [CB1-1:0] c);
        return v[{c, 4'b0000} +: 16];
    endfunction

    logic [16:0]      w_diff;
    logic [15:0]      w_offset;
    logic             w_in_range;
    logic [AW-1:0]    w_word;
    logic [CB1-1:0]   w_chunk;
    logic             w_rd, w_stage, w_commit;
    logic [PAD_W-1:0] w_din_pad;

    logic [PAD_W-1:0] r_stage;
    logic             r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
    logic             r_rw_p1, r_rw_p2, r_rw_p3, r_rw_p4;
    logic             r_rd_p1, r_rd_p2, r_rd_p3;
    logic [15:0]      r_addr_p1, r_addr_p2, r_addr_p3, r_addr_p4;
    logic [15:0]      r_data_p1, r_data_p2, r_data_p3, r_data_p4;
    logic [CB1-1:0]   r_chunk_p1, r_chunk_p2, r_chunk_p3;
    logic [AW-1:0]    r_bram_addr;
    logic [RAM_WIDTH-1:0] r_bram_din;
    logic             r_bram_we, r_bram_en;

    // The borrow bit of the 17-bit subtraction flags addresses below BASE_ADDR.
    always_comb begin
        w_diff     = {1'b0, bus.addr_i} - {1'b0, BASE};
        w_offset   = w_diff[15:0];
        w_in_range = !w_diff[16] && ({1'b0, w_offset} < 17'(SPAN));
        w_word     = AW'(w_offset >> CHUNK_BITS);
        w_chunk    = w_offset[CB1-1:0] & CHUNK_MASK;
        w_rd       = bus.valid_i && w_in_range && !bus.rw_i;
        w_stage    = bus.valid_i && w_in_range && bus.rw_i && (w_chunk < LAST_CHUNK);
        w_commit   = bus.valid_i && w_in_range && bus.rw_i && (w_chunk == LAST_CHUNK);
        w_din_pad  = r_stage;
        w_din_pad[LAST_IDX*16 +: 16] = bus.data_i;
    end

    always_ff @(posedge clk) begin
        // stage p1: sample the bus beat
        r_addr_p1  <= bus.addr_i;
        r_data_p1  <= bus.data_i;
        r_rw_p1    <= bus.rw_i;
        r_rd_p1    <= w_rd;
        r_chunk_p1 <= w_chunk;
        // stage p2: RAM port latches the address
        r_addr_p2  <= r_addr_p1;
        r_data_p2  <= r_data_p1;
        r_rw_p2    <= r_rw_p1;
        r_rd_p2    <= r_rd_p1;
        r_chunk_p2 <= r_chunk_p1;
        // stage p3: RAM output register loads; bram_dout is valid during p3
        r_addr_p3  <= r_addr_p2;
        r_data_p3  <= r_data_p2;
        r_rw_p3    <= r_rw_p2;
        r_rd_p3    <= r_rd_p2;
        r_chunk_p3 <= r_chunk_p2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_vld_p3    <= 1'b0;
            r_vld_p4    <= 1'b0;
            r_rw_p4     <= 1'b0;
            r_addr_p4   <= '0;
            r_data_p4   <= '0;
            r_stage     <= '0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            r_vld_p1  <= bus.valid_i;
            r_vld_p2  <= r_vld_p1;
            r_vld_p3  <= r_vld_p2;
            r_bram_en <= w_rd || w_commit;
            r_bram_we <= w_commit;
            if (w_rd || w_commit)
                r_bram_addr <= w_word;
            if (w_commit)
                r_bram_din <= w_din_pad[RAM_WIDTH-1:0];
            // Staging survives a commit so later words reuse whatever is left in it.
            if (w_stage)
                r_stage[{w_chunk, 4'b0000} +: 16] <= bus.data_i;
            // stage p4: registered bus outputs, zeroed for idle beats
            r_vld_p4 <= r_vld_p3;
            if (r_vld_p3) begin
                r_rw_p4   <= r_rw_p3;
                r_addr_p4 <= r_addr_p3;
                r_data_p4 <= r_rd_p3 ? chunk_of(PAD_W'(bram_dout), r_chunk_p3) : r_data_p3;
            end else begin
                r_rw_p4   <= 1'b0;
                r_addr_p4 <= '0;
                r_data_p4 <= '0;
            end
        end
    end

    assign bus.valid_o = r_vld_p4;
    assign bus.rw_o    = r_rw_p4;
    assign bus.addr_o  = r_addr_p4;
    assign bus.data_o  = r_data_p4;
    assign bram_en     = r_bram_en;
    assign bram_we     = r_bram_we;
    assign bram_addr   = r_bram_addr;
    assign bram_din    = r_bram_din;
endmodule

// File: tb/tb_bram_bus_port.sv
// Bench for bram_bus_port: an 18-bit wide instance checked cycle by cycle against a
// word/staging reference model, plus an 8-bit single-chunk instance checked per transaction.
module tb_bram_bus_port;
    localparam int RW1   = 18;
    localparam int DEP1  = 1024;
    localparam int BASE1 = 'h1000;
    localparam int NCH1  = (RW1 + 15) / 16;
    localparam int CB    = $clog2(NCH1);
    localparam int SPAN1 = DEP1 * (1 << CB);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_bus_port_if bus1();
    bram_bus_port_if bus2();

    logic [9:0]  baddr1;
    logic [17:0] bdin1;
    logic        bwe1, ben1;
    logic [17:0] ram1 [DEP1] = '{default: '0};
    logic [17:0] ram1_q = '0;
    logic [17:0] bdout1 = '0;

    logic [3:0]  baddr2;
    logic [7:0]  bdin2;
    logic        bwe2, ben2;
    logic [7:0]  ram2 [16] = '{default: '0};
    logic [7:0]  ram2_q = '0;
    logic [7:0]  bdout2 = '0;

    bram_bus_port #(.BASE_ADDR(BASE1), .RAM_WIDTH(RW1), .RAM_DEPTH(DEP1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .bram_addr(baddr1), .bram_din(bdin1), .bram_we(bwe1), .bram_en(ben1), .bram_dout(bdout1)
    );

    bram_bus_port #(.BASE_ADDR(0), .RAM_WIDTH(8), .RAM_DEPTH(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .bram_addr(baddr2), .bram_din(bdin2), .bram_we(bwe2), .bram_en(ben2), .bram_dout(bdout2)
    );

    // Read-first RAMs with an output register: two cycles of read latency.
    always @(posedge clk) begin
        if (ben1) begin
            if (bwe1) ram1[baddr1] <= bdin1;
            ram1_q <= ram1[baddr1];
        end
        bdout1 <= ram1_q;
        if (ben2) begin
            if (bwe2) ram2[baddr2] <= bdin2;
            ram2_q <= ram2[baddr2];
        end
        bdout2 <= ram2_q;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model state: RAM words, staging bits, and expected results per edge slot.
    bit [17:0] ref_mem [DEP1];
    bit [63:0] ref_stage;
    bit        ex_vld [64], ex_rw [64], ex_en [64], ex_we [64], ex_rst [64];
    bit [15:0] ex_addr [64], ex_data [64];
    bit [9:0]  ex_baddr [64];
    bit [17:0] ex_bdin [64];
    int        cyc = 0;

    task automatic clr_slot(input int i);
        ex_vld[i]  = 1'b0;
        ex_rw[i]   = 1'b0;
        ex_addr[i] = '0;
        ex_data[i] = '0;
    endtask

    initial begin
        int s, t, off, word, ch;
        bit [63:0] val;
        for (int i = 0; i < DEP1; i++) ref_mem[i] = '0;
        for (int i = 0; i < 64; i++) begin
            clr_slot(i);
            ex_en[i] = 1'b0; ex_we[i] = 1'b0; ex_rst[i] = 1'b0;
        end
        ref_stage = '0;
        forever begin
            @(posedge clk);
            cyc++;
            s = cyc % 64;
            t = (cyc + 3) % 64;
            ex_en[s] = 1'b0;
            ex_we[s] = 1'b0;
            if (!rst_n) begin
                ref_stage = '0;
                for (int k = 0; k < 4; k++) clr_slot((cyc + k) % 64);
                ex_rst[s] = 1'b1;
            end else begin
                ex_rst[s] = 1'b0;
                clr_slot(t);
                if (bus1.valid_i) begin
                    off  = int'(bus1.addr_i) - BASE1;
                    word = (off >= 0) ? off / (1 << CB) : 0;
                    ch   = (off >= 0) ? off % (1 << CB) : 0;
                    ex_vld[t]  = 1'b1;
                    ex_rw[t]   = bus1.rw_i;
                    ex_addr[t] = bus1.addr_i;
                    ex_data[t] = bus1.data_i;
                    if (off >= 0 && off < SPAN1) begin
                        if (!bus1.rw_i) begin
                            ex_en[s]    = 1'b1;
                            ex_baddr[s] = 10'(word);
                            ex_data[t]  = (ch < NCH1) ? 16'(ref_mem[word] >> (16 * ch)) : 16'h0;
                        end else if (ch < NCH1 - 1) begin
                            ref_stage[16*ch +: 16] = bus1.data_i;
                        end else if (ch == NCH1 - 1) begin
                            val = (ref_stage & ((64'd1 << (16 * (NCH1 - 1))) - 1))
                                | (64'(bus1.data_i) << (16 * (NCH1 - 1)));
                            ref_mem[word] = val[17:0];
                            ex_en[s]    = 1'b1;
                            ex_we[s]    = 1'b1;
                            ex_baddr[s] = 10'(word);
                            ex_bdin[s]  = val[17:0];
                        end
                    end
                end
            end
        end
    end

    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                s = cyc % 64;
                chk("bus", 64'({bus1.valid_o, bus1.rw_o, bus1.addr_o, bus1.data_o}),
                    64'({ex_vld[s], ex_rw[s], ex_addr[s], ex_data[s]}));
                chk("bram_en", 64'(ben1), 64'(ex_en[s]));
                chk("bram_we", 64'(bwe1), 64'(ex_we[s]));
                if (ex_en[s]) chk("bram_addr", 64'(baddr1), 64'(ex_baddr[s]));
                if (ex_we[s]) chk("bram_din", 64'(bdin1), 64'(ex_bdin[s]));
                if (ex_rst[s]) chk("bram_rst", 64'({baddr1, bdin1}), 64'(0));
            end
        end
    end

    task automatic beat(input bit v, input bit rw, input logic [15:0] a, input logic [15:0] d);
        bus1.valid_i = v;
        bus1.rw_i    = rw;
        bus1.addr_i  = a;
        bus1.data_i  = d;
        @(negedge clk);
    endtask

    bit [7:0] mem2 [16];

    task automatic t2(input bit rw, input logic [15:0] a, input logic [15:0] d);
        bit inr;
        logic [15:0] exp_o;
        inr = (a < 16);
        bus2.valid_i = 1'b1; bus2.rw_i = rw; bus2.addr_i = a; bus2.data_i = d;
        @(negedge clk);
        bus2.valid_i = 1'b0; bus2.rw_i = 1'b0; bus2.addr_i = '0; bus2.data_i = '0;
        chk("sc_en", 64'(ben2), 64'(inr));
        chk("sc_we", 64'(bwe2), 64'(inr && rw));
        if (inr) chk("sc_addr", 64'(baddr2), 64'(a[3:0]));
        if (inr && rw) chk("sc_din", 64'(bdin2), 64'(d[7:0]));
        exp_o = (inr && !rw) ? {8'h00, mem2[a[3:0]]} : d;
        if (inr && rw) mem2[a[3:0]] = d[7:0];
        repeat (2) @(negedge clk);
        chk("sc_early", 64'(bus2.valid_o), 64'(0));
        @(negedge clk);
        chk("sc_bus", 64'({bus2.valid_o, bus2.rw_o, bus2.addr_o, bus2.data_o}),
            64'({1'b1, rw, a, exp_o}));
    endtask

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 16; i++) mem2[i] = '0;
        bus2.valid_i = 1'b0; bus2.rw_i = 1'b0; bus2.addr_i = '0; bus2.data_i = '0;
        bus1.valid_i = 1'b0; bus1.rw_i = 1'b0; bus1.addr_i = '0; bus1.data_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // split write then read
        beat(1, 1, 16'h1000, 16'h1234);
        beat(1, 1, 16'h1001, 16'h0003);
        beat(1, 0, 16'h1000, 16'h5555);
        beat(1, 0, 16'h1001, 16'h6666);
        // partial-chunk truncation
        beat(1, 1, 16'h1002, 16'h0000);
        beat(1, 1, 16'h1003, 16'hFFFF);
        beat(1, 0, 16'h1003, 16'h0000);
        beat(0, 0, 16'h0000, 16'h0000);
        // out of range on both sides
        beat(1, 0, 16'h0FFF, 16'hBEEF);
        beat(1, 0, 16'h1800, 16'hBEEF);
        // preload words 0..7, then 16 back-to-back reads
        for (int w = 0; w < 8; w++) begin
            beat(1, 1, 16'(16'h1000 + 2 * w), 16'($urandom));
            beat(1, 1, 16'(16'h1001 + 2 * w), 16'($urandom));
        end
        for (int i = 0; i < 16; i++) beat(1, 0, 16'(16'h1000 + i), 16'($urandom));
        repeat (5) beat(0, 0, 16'h0000, 16'h0000);
        // reset mid-flight, then staging must read back as zero
        beat(1, 1, 16'h1002, 16'hAAAA);
        beat(1, 0, 16'h1000, 16'h0000);
        beat(1, 0, 16'h1001, 16'h0000);
        rst_n = 1'b0;
        beat(1, 0, 16'h1002, 16'h0000);
        rst_n = 1'b1;
        repeat (4) beat(0, 0, 16'h0000, 16'h0000);
        beat(1, 1, 16'h1001, 16'h0001);
        beat(1, 0, 16'h1001, 16'h0000);
        beat(1, 0, 16'h1000, 16'h0000);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: a = 16'(16'h1000 + $urandom_range(31));
                1: a = 16'(16'h1000 + $urandom_range(SPAN1 - 1));
                2: a = 16'(16'h0FF8 + $urandom_range(15));
                default: a = 16'($urandom);
            endcase
            beat($urandom_range(3) != 0, 1'($urandom_range(1)), a, 16'($urandom));
        end
        repeat (6) beat(0, 0, 16'h0000, 16'h0000);

        // single-chunk instance
        t2(1, 16'h0005, 16'hABCD);
        t2(0, 16'h0005, 16'h1111);
        t2(0, 16'h0010, 16'hBEEF);
        for (int i = 0; i < 20; i++)
            t2(1'($urandom_range(1)), 16'($urandom_range(19)), 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bram_bus_port.md
# bram_bus_port

Bus-side responder that lets the host read and write a dual-port block RAM through one of its ports, using the core bus protocol. The core bus carries 16-bit address, 16-bit data, rw and valid. RAM words wider than 16 bits are exposed as several consecutive 16-bit bus registers. Every bus transaction passes through a fixed 4-cycle pipeline. In-range reads get the RAM contents substituted into the data field; in-range writes are staged and committed to the RAM.

## Interface
Parameters:
- BASE_ADDR, 0, first bus address claimed by this block.
- RAM_WIDTH, 18, width of one RAM word in bits.
- RAM_DEPTH, 1024, number of RAM words.
- Derived values:
  - N_CHUNKS = ceil(RAM_WIDTH/16).
  - CHUNK_BITS = clog2(N_CHUNKS); this is 0 when N_CHUNKS=1.
  - AW = clog2(RAM_DEPTH).
  - SPAN = RAM_DEPTH << CHUNK_BITS; BASE_ADDR+SPAN must not exceed 65536.

Ports:
- clk  in  1  sole clock; also drives the RAM port this block controls.
- rst_n  in  1  reset, synchronous, active-low.
- addr_i  in  16  bus address in.
- data_i  in  16  bus data in.
- rw_i  in  1  1 = write, 0 = read.
- valid_i  in  1  bus transaction strobe.
- addr_o  out  16  bus address out.
- data_o  out  16  bus data out.
- rw_o  out  1  bus rw out.
- valid_o  out  1  bus valid out.
- bram_addr  out  AW  RAM port address.
- bram_din  out  RAM_WIDTH  RAM port write data.
- bram_we  out  1  RAM port write enable.
- bram_en  out  1  RAM port enable.
- bram_dout  in  RAM_WIDTH  RAM port read data. The RAM runs in read-first mode with an output register, so read latency is 2 cycles. Its regce is tied 1 and its output reset is tied 0 at instantiation.

## Operation
- Address decode:
  - offset = addr_i - BASE_ADDR.
  - A transaction is in range iff addr_i >= BASE_ADDR and offset < SPAN.
  - word = offset >> CHUNK_BITS.
  - chunk = offset[CHUNK_BITS-1:0]; chunk is 0 when CHUNK_BITS=0.
  - Chunk 0 holds RAM bits [15:0], chunk k holds bits [16k+15:16k].
  - Chunk indices >= N_CHUNKS are holes: reads of a hole return 0 and writes to a hole are ignored.
- Pass-through:
  - Every input beat (valid_i=1) reappears on the outputs exactly 4 cycles later, with addr and rw unchanged.
  - data_o is unchanged except for in-range reads.
  - Beats with valid_i=0 propagate as valid_o=0, with addr/data/rw outputs forced to 0.
- In-range read:
  - Cycle 1: bram_en=1, bram_we=0, bram_addr=word.
  - data_o = bram_dout[chunk slice], zero-extended when the last chunk is partial.
- In-range write to a chunk below N_CHUNKS-1:
  - data_i is latched into the staging register slice for that chunk.
  - No RAM access occurs (bram_en=0).
- In-range write to chunk N_CHUNKS-1:
  - Cycle 1: bram_en=1, bram_we=1, bram_addr=word.
  - bram_din = {data_i[RAM_WIDTH-16(N_CHUNKS-1)-1:0], staging[16(N_CHUNKS-1)-1:0]}. Bits of data_i beyond RAM_WIDTH are discarded.
  - The staging register is retained after commit; it is not cleared.
  - When N_CHUNKS=1, every write commits directly.
- Out-of-range beats never assert bram_en and never touch staging.
- The staging register is shared across words. The host must write chunks 0..N-1 of one word in order. Interleaving words yields mixed data, by design.

## Timing
- Pipeline stages:
  - Cycle 0: inputs sampled.
  - Cycle 1: bram_* outputs registered.
  - Cycle 3: bram_dout valid.
  - Cycle 4: bus outputs registered.
- Fully pipelined: one transaction per cycle with no stalls or backpressure.
- bram_en and bram_we are single-cycle pulses per transaction.
- Read after write:
  - A write commit in cycle N, followed by a read of the same word issued one cycle later, returns the new data.
  - A same-cycle read on the other RAM port sees the old data (read-first).
- Reset while rst_n=0, applied at the next clk edge:
  - valid_o, rw_o, addr_o and data_o become 0.
  - bram_en, bram_we, bram_addr and bram_din become 0.
  - Staging becomes 0 and all pipeline valids are cleared.
  - In-flight transactions are dropped; RAM contents are untouched.
- Outputs are 0 in the first cycle after reset deassertion. The first valid_o can appear 4 cycles after the first accepted valid_i.

## Test plan
Unless noted, parameters are RAM_WIDTH=18, RAM_DEPTH=1024, BASE_ADDR=0x1000.
- **Split write then read:**
  - Write 0x1234 to 0x1000, then 0x0003 to 0x1001.
  - The first write gives no bram_en. The second gives one cycle of bram_we=1 with bram_addr=0 and bram_din=0x31234.
  - Reads of 0x1000 and 0x1001 return data_o=0x1234 and 0x0003 at +4 cycles.
- **Partial-chunk truncation:**
  - Write 0x0000 to 0x1002, then 0xFFFF to 0x1003.
  - bram_din=0x30000; a read of 0x1003 returns 0x0003.
- **Out of range:**
  - Read 0x0FFF with data 0xBEEF, then read 0x1800 with data 0xBEEF.
  - Both return unchanged at +4 cycles with bram_en=0 throughout.
- **Back-to-back:**
  - Preload words 0..7, then issue 16 consecutive reads of 0x1000..0x100F with valid held high.
  - 16 consecutive valid_o beats arrive starting 4 cycles later, each with correct data and no gaps.
- **Reset mid-flight:**
  - Issue 3 reads, then drive rst_n=0 for one cycle after the second.
  - No valid_o results from any of the dropped reads. Staging reads back 0: a subsequent single write of 0x0001 to 0x1001 commits bram_din=0x10000.
- **Single-chunk config** (RAM_WIDTH=8, BASE_ADDR=0):
  - Write 0xABCD to 0x0005.
  - bram_din=0xCD at addr 5, and a read returns 0x00CD.
